memory_arbiter: RTL and testbench

Single-port memory arbiter: the responder side of the cache-to-memory interface. It accepts word requests from the icache and dcache, grants one at a time to the RAM port, and drives each cache's wait/load return. It sits between the two caches and RAM, replacing the purely combinational controller with a registered grant FSM that adds an icache starvation guard.

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/memory_arbiter.sv | 121 ++++++++++++
 tb/tb_memory_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-system types: word, RAM handshake state, arbiter FSM state.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // RAM handshake state reported back by the memory model/controller.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Arbiter grant state; kept here so benches can name the encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DGNT = 2'd1,
    IGNT = 2'd2
  } arb_state_t;

  localparam int STARVE_W = 4;

endpackage

// File: rtl/memory_arbiter.sv
// Arbitrates icache/dcache word requests onto a single RAM port with an icache starvation guard.
// Latency: 1 arbitration cycle in IDLE, then 1+ grant cycles until RAM reports ACCESS; 1 bubble after each completion.
// Backpressure: the non-granted cache and any granted cache not yet completed see wait=1; RAM BUSY/FREE/ERROR hold the grant.
//
// Ports:
//   CLK, nRST                  clock, async active-low reset
//   iREN, iaddr -> iwait, iload                 icache read channel
//   dREN, dWEN, daddr, dstore -> dwait, dload   dcache read/write channel
//   ramREN, ramWEN, ramaddr, ramstore <- ramload, ramstate   RAM port
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_LIMIT[STARVE_W-1:0];

  arb_state_t          r_state;
  logic [STARVE_W-1:0] r_starve_cnt;

  arb_state_t          w_state_nxt;
  logic [STARVE_W-1:0] w_starve_nxt;
  logic                w_dreq;
  logic                w_access;
  logic                w_d_done;
  logic                w_i_done;

  assign w_dreq   = dREN | dWEN;
  assign w_access = (ramstate == ACCESS);
  // A dropped request aborts even if RAM happens to report ACCESS that cycle.
  assign w_d_done = (r_state == DGNT) & w_dreq & w_access;
  assign w_i_done = (r_state == IGNT) & iREN & w_access;

  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve_cnt;
    case (r_state)
      IDLE: begin
        if (w_dreq && (r_starve_cnt < LIMIT)) begin
          w_state_nxt = DGNT;
        end else if (iREN && (!w_dreq || (r_starve_cnt == LIMIT))) begin
          w_state_nxt = IGNT;
        end else begin
          w_state_nxt = IDLE;
        end
        // Count only dcache wins that leave a pending icache waiting.
        if (!iREN || (w_state_nxt == IGNT)) begin
          w_starve_nxt = '0;
        end else if ((w_state_nxt == DGNT) && (r_starve_cnt < LIMIT)) begin
          w_starve_nxt = r_starve_cnt + 1'b1;
        end
      end
      DGNT: begin
        if (!w_dreq || w_access) w_state_nxt = IDLE;
      end
      IGNT: begin
        if (!iREN || w_access) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  // Outputs are decoded from the registered state and live inputs only.
  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (r_state)
      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dwait    = ~w_d_done;
        dload    = w_d_done ? ramload : '0;
      end
      IGNT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iwait   = ~w_i_done;
        iload   = w_i_done ? ramload : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int LIM = 4;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore, ramload;
  ramstate_t ramstate;
  logic      iwait, dwait, ramREN, ramWEN;
  word_t     iload, dload, ramaddr, ramstore;

  int errors = 0;
  int checks = 0;

  memory_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural reference model ----------------
  // owner: 0 = nobody holds the RAM, 1 = dcache holds it, 2 = icache holds it
  int m_owner = 0;
  int m_cnt   = 0;
  logic  e_iwait, e_dwait, e_ren, e_wen;
  word_t e_iload, e_dload, e_addr, e_store;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_outputs();
    bit done;
    e_iwait = 1; e_dwait = 1; e_iload = 0; e_dload = 0;
    e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0;
    if (m_owner == 1) begin
      done    = (dREN || dWEN) && ramstate == ACCESS;
      e_addr  = daddr;
      e_store = dstore;
      e_wen   = dWEN;
      e_ren   = dREN && !dWEN;
      e_dwait = !done;
      e_dload = done ? ramload : 32'h0;
    end else if (m_owner == 2) begin
      done    = iREN && ramstate == ACCESS;
      e_addr  = iaddr;
      e_ren   = iREN;
      e_iwait = !done;
      e_iload = done ? ramload : 32'h0;
    end
  endtask

  task automatic model_step();
    bit dreq;
    dreq = dREN || dWEN;
    if (m_owner == 0) begin
      if (dreq && m_cnt < LIM) begin
        m_owner = 1;
        m_cnt   = iREN ? ((m_cnt + 1 > LIM) ? LIM : m_cnt + 1) : 0;
      end else if (iREN && (!dreq || m_cnt == LIM)) begin
        m_owner = 2;
        m_cnt   = 0;
      end else if (!iREN) begin
        m_cnt = 0;
      end
    end else if (m_owner == 1) begin
      if (!dreq || ramstate == ACCESS) m_owner = 0;
    end else begin
      if (!iREN || ramstate == ACCESS) m_owner = 0;
    end
  endtask

  task automatic check_vs_model(input string tag);
    model_outputs();
    check({tag, ".iwait"},    32'(iwait),    32'(e_iwait));
    check({tag, ".dwait"},    32'(dwait),    32'(e_dwait));
    check({tag, ".iload"},    iload,         e_iload);
    check({tag, ".dload"},    dload,         e_dload);
    check({tag, ".ramREN"},   32'(ramREN),   32'(e_ren));
    check({tag, ".ramWEN"},   32'(ramWEN),   32'(e_wen));
    check({tag, ".ramaddr"},  ramaddr,       e_addr);
    check({tag, ".ramstore"}, ramstore,      e_store);
    check({tag, ".starve"},   32'(dut.r_starve_cnt), 32'(m_cnt));
  endtask

  // Inputs are driven just after a negedge; outputs checked 1 time unit later;
  // the model advances on the posedge using the same inputs.
  task automatic model_cycle(input string tag);
    #1;
    check_vs_model(tag);
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic clear_inputs();
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".iwait"},    32'(iwait),    32'd1);
    check({tag, ".dwait"},    32'(dwait),    32'd1);
    check({tag, ".iload"},    iload,         32'd0);
    check({tag, ".dload"},    dload,         32'd0);
    check({tag, ".ramREN"},   32'(ramREN),   32'd0);
    check({tag, ".ramWEN"},   32'(ramWEN),   32'd0);
    check({tag, ".ramaddr"},  ramaddr,       32'd0);
    check({tag, ".ramstore"}, ramstore,      32'd0);
    check({tag, ".state"},    32'(dut.r_state), 32'(IDLE));
    check({tag, ".starve"},   32'(dut.r_starve_cnt), 32'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic iren; word_t ia; logic dren; logic dwen; word_t da; word_t ds;
    ramstate_t rs; word_t rl;
    logic x_iwait; logic x_dwait; word_t x_iload; word_t x_dload;
    logic x_ren; logic x_wen; word_t x_addr; word_t x_store;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int dcomp;
    int budget;
    bit seen_i;

    // icache read of 0x40: BUSY, BUSY, ACCESS
    vecs[0] = '{1, 32'h40, 0, 0, 0, 0, FREE,   32'hDEADBEEF, 1, 1, 0, 0, 0, 0, 32'h0,  0};
    vecs[1] = '{1, 32'h40, 0, 0, 0, 0, BUSY,   32'hDEADBEEF, 1, 1, 0, 0, 1, 0, 32'h40, 0};
    vecs[2] = '{1, 32'h40, 0, 0, 0, 0, BUSY,   32'hDEADBEEF, 1, 1, 0, 0, 1, 0, 32'h40, 0};
    vecs[3] = '{1, 32'h40, 0, 0, 0, 0, ACCESS, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 0, 1, 0, 32'h40, 0};
    vecs[4] = '{0, 32'h0,  0, 0, 0, 0, FREE,   32'h0,        1, 1, 0, 0, 0, 0, 32'h0,  0};
    // dcache write 0x12345678 -> 0x100 with both enables high; write wins
    vecs[5] = '{0, 0, 1, 1, 32'h100, 32'h12345678, BUSY,   32'hCAFEF00D, 1, 1, 0, 0, 0, 0, 32'h0,   32'h0};
    vecs[6] = '{0, 0, 1, 1, 32'h100, 32'h12345678, BUSY,   32'hCAFEF00D, 1, 1, 0, 0, 0, 1, 32'h100, 32'h12345678};
    vecs[7] = '{0, 0, 1, 1, 32'h100, 32'h12345678, ACCESS, 32'hCAFEF00D, 1, 0, 0, 32'hCAFEF00D, 0, 1, 32'h100, 32'h12345678};
    // ERROR is not completion: dcache read held through ERROR
    vecs[8] = '{0, 0, 1, 0, 32'h200, 32'h0, ERROR,  32'h11111111, 1, 1, 0, 0, 0, 0, 32'h0,   32'h0};
    vecs[9] = '{0, 0, 1, 0, 32'h200, 32'h0, ERROR,  32'h11111111, 1, 1, 0, 0, 1, 0, 32'h200, 32'h0};

    clear_inputs();
    nRST = 0;
    #3;
    check_reset_values("reset");
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1;

    for (int k = 0; k < 10; k++) begin
      iREN = vecs[k].iren; iaddr = vecs[k].ia;
      dREN = vecs[k].dren; dWEN = vecs[k].dwen; daddr = vecs[k].da; dstore = vecs[k].ds;
      ramstate = vecs[k].rs; ramload = vecs[k].rl;
      #1;
      check($sformatf("vec%0d.iwait", k),    32'(iwait),    32'(vecs[k].x_iwait));
      check($sformatf("vec%0d.dwait", k),    32'(dwait),    32'(vecs[k].x_dwait));
      check($sformatf("vec%0d.iload", k),    iload,         vecs[k].x_iload);
      check($sformatf("vec%0d.dload", k),    dload,         vecs[k].x_dload);
      check($sformatf("vec%0d.ramREN", k),   32'(ramREN),   32'(vecs[k].x_ren));
      check($sformatf("vec%0d.ramWEN", k),   32'(ramWEN),   32'(vecs[k].x_wen));
      check($sformatf("vec%0d.ramaddr", k),  ramaddr,       vecs[k].x_addr);
      check($sformatf("vec%0d.ramstore", k), ramstore,      vecs[k].x_store);
      @(posedge CLK);
      model_step();
      @(negedge CLK);
    end
    // finish the held dcache read so the bench restarts from IDLE
    ramstate = ACCESS; ramload = 32'h0BADF00D;
    model_cycle("err_done");
    clear_inputs();
    model_cycle("idle0");

    // Simultaneous requests from IDLE: dcache first, then icache after one bubble
    iREN = 1; iaddr = 32'h80; dREN = 1; daddr = 32'h300; ramstate = ACCESS; ramload = 32'h5A5A5A5A;
    model_cycle("both.idle");
    #1; check("both.dgnt_first", 32'(dwait), 32'd0); check("both.i_waits", 32'(iwait), 32'd1);
    check_vs_model("both.dgnt");
    @(posedge CLK); model_step(); @(negedge CLK);
    dREN = 0;
    model_cycle("both.bubble");
    #1; check("both.igrant", 32'(iwait), 32'd0); check("both.iload", iload, 32'h5A5A5A5A);
    check_vs_model("both.ignt");
    @(posedge CLK); model_step(); @(negedge CLK);
    clear_inputs();
    model_cycle("idle1");

    // Starvation guard: exactly LIM dcache completions before icache wins
    iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h400; ramstate = ACCESS; ramload = 32'h77;
    dcomp = 0; seen_i = 0; budget = 0;
    while (!seen_i && budget < 30) begin
      #1;
      check_vs_model("starve");
      if (!dwait) dcomp++;
      if (!iwait) seen_i = 1;
      @(posedge CLK); model_step(); @(negedge CLK);
      budget++;
    end
    check("starve.icache_granted", 32'(seen_i), 32'd1);
    check("starve.dcache_completions", 32'(dcomp), 32'(LIM));
    #1; check("starve.count_cleared", 32'(dut.r_starve_cnt), 32'd0);
    clear_inputs();
    model_cycle("idle2");

    // dcache read dropped while BUSY: abort, no completion
    dREN = 1; daddr = 32'h500; ramstate = BUSY;
    model_cycle("drop.idle");
    model_cycle("drop.busy");
    dREN = 0;
    #1;
    check("drop.ramREN", 32'(ramREN), 32'd0);
    check("drop.ramWEN", 32'(ramWEN), 32'd0);
    check("drop.dwait", 32'(dwait), 32'd1);
    @(posedge CLK); model_step(); @(negedge CLK);
    #1; check("drop.state_idle", 32'(dut.r_state), 32'(IDLE));
    @(negedge CLK);

    // Reset pulsed mid-IGNT while BUSY
    iREN = 1; iaddr = 32'h600; ramstate = BUSY;
    model_cycle("rst.idle");
    #1; check("rst.granted", 32'(ramREN), 32'd1);
    #1; nRST = 0;
    #1; check_reset_values("rst.mid");
    @(negedge CLK);
    nRST = 1; m_owner = 0; m_cnt = 0;
    clear_inputs();
    #1; check_reset_values("rst.after");
    @(negedge CLK);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) iREN = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) begin
        dREN = $urandom_range(0, 1);
        dWEN = ($urandom_range(0, 2) == 0);
      end
      if ($urandom_range(0, 5) == 0) iaddr = $urandom;
      if ($urandom_range(0, 5) == 0) daddr = $urandom;
      if ($urandom_range(0, 5) == 0) dstore = $urandom;
      ramload  = $urandom;
      ramstate = ramstate_t'($urandom_range(0, 3));
      model_cycle($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
